// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way data cache: FSM encoding and tree pseudo-LRU helpers.
package dcache_pkg;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_OK} state_t;

  // Tree bits: [0] root, [1] ways 0/1, [2] ways 2/3; each bit names the side to evict next.
  function automatic logic [2:0] plru_touch(input int ways, input logic [2:0] bits,
                                            input logic [1:0] way);
    logic [2:0] nb;
    nb = bits;
    if (ways == 2) begin
      nb[0] = ~way[0];
    end else if (ways == 4) begin
      nb[0] = ~way[1];
      if (way[1]) nb[2] = ~way[0];
      else        nb[1] = ~way[0];
    end
    return nb;
  endfunction

  function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] bits);
    logic [1:0] v;
    v = 2'd0;
    if (ways == 2)      v = {1'b0, bits[0]};
    else if (ways == 4) v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    return v;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag/line arrays with combinational read and synchronous write.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int SETS      = 32,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 22
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(SETS)-1:0]         index,
  input  logic [$clog2(LINE_BITS/32)-1:0] word,
  output logic                            valid,
  output logic                            dirty,
  output logic [TAG_W-1:0]                tag,
  output logic [LINE_BITS-1:0]            line,
  input  logic                            line_we,
  input  logic [TAG_W-1:0]                new_tag,
  input  logic [LINE_BITS-1:0]            new_line,
  input  logic                            word_we,
  input  logic [31:0]                     new_word
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] line_q [SETS];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = line_q[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; only valid/dirty qualify them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= new_tag;
      line_q[index] <= new_line;
    end else if (word_we) begin
      line_q[index][{word, 5'b00000} +: 32] <= new_word;
    end
  end

endmodule

// File: rtl/dcache_nway_top.sv
// N-way set-associative write-back data cache with tree PLRU replacement.
// Optional performance counters are built when DCACHE_STATS_EN is defined.
module dcache_nway_top
  import dcache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 32,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [31:0]          p1_data_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic [31:0]          stat_hits_o,
  output logic [31:0]          stat_misses_o
);

  localparam int OFFSET_W = $clog2(LINE_BITS / 8);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W   = OFFSET_W - 2;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;

  logic [TAG_W-1:0]   p1_tag;
  logic [INDEX_W-1:0] p1_index;
  logic [WORD_W-1:0]  p1_word;
  logic               unused_addr_lsb;

  assign p1_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign p1_index        = p1_addr_i[OFFSET_W +: INDEX_W];
  assign p1_word         = p1_addr_i[2 +: WORD_W];
  assign unused_addr_lsb = ^p1_addr_i[1:0];

  logic [WAYS-1:0]      way_valid, way_dirty, way_hit, line_we, word_we;
  logic [TAG_W-1:0]     way_tag  [WAYS];
  logic [LINE_BITS-1:0] way_line [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(.SETS(SETS), .LINE_BITS(LINE_BITS), .TAG_W(TAG_W)) u_way (
      .clk      (clk_i),
      .rst      (rst_i),
      .index    (p1_index),
      .word     (p1_word),
      .valid    (way_valid[w]),
      .dirty    (way_dirty[w]),
      .tag      (way_tag[w]),
      .line     (way_line[w]),
      .line_we  (line_we[w]),
      .new_tag  (p1_tag),
      .new_line (mem_data_i),
      .word_we  (word_we[w]),
      .new_word (p1_data_i)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == p1_tag);
  end

  logic             plru_we;
  logic [WAY_W-1:0] plru_way;
  logic [2:0]       plru_cur;

  if (WAYS > 1) begin : g_plru
    logic [PLRU_W-1:0] plru_q [SETS];
    assign plru_cur = 3'(plru_q[p1_index]);
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (plru_we) begin
        plru_q[p1_index] <= PLRU_W'(plru_touch(WAYS, plru_cur, 2'(plru_way)));
      end
    end
  end else begin : g_no_plru
    logic unused_plru;
    assign plru_cur    = '0;
    assign unused_plru = plru_we ^ plru_way[0];
  end

  logic             hit, req;
  logic [WAY_W-1:0] hit_way, victim_sel, victim_q, victim_d;

  // Descending scans so the lowest-index match or invalid way wins.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_sel = WAY_W'(plru_victim(WAYS, plru_cur));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) victim_sel = WAY_W'(w);
    end
  end

  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign p1_data_o  = way_line[hit_way][{p1_word, 5'b00000} +: 32];

  state_t               state, state_d;
  logic                 enable_d, write_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [LINE_BITS-1:0] wb_data_d;

  assign p1_stall_o = req & (~hit | (state != IDLE));

  always_comb begin
    state_d   = state;
    victim_d  = victim_q;
    enable_d  = mem_enable_o;
    write_d   = mem_write_o;
    addr_d    = mem_addr_o;
    wb_data_d = mem_data_o;
    line_we   = '0;
    word_we   = '0;
    plru_we   = 1'b0;
    plru_way  = hit_way;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          state_d  = MISS;
          victim_d = victim_sel;
        end else if (req) begin
          plru_we = 1'b1;
          if (p1_MemWrite_i) word_we[hit_way] = 1'b1;
        end
      end
      MISS: begin
        enable_d = 1'b1;
        if (way_valid[victim_q] && way_dirty[victim_q]) begin
          write_d   = 1'b1;
          addr_d    = {way_tag[victim_q], p1_index, {OFFSET_W{1'b0}}};
          wb_data_d = way_line[victim_q];
          state_d   = WRITEBACK;
        end else begin
          write_d = 1'b0;
          addr_d  = {p1_tag, p1_index, {OFFSET_W{1'b0}}};
          state_d = REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          write_d = 1'b0;
          addr_d  = {p1_tag, p1_index, {OFFSET_W{1'b0}}};
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          line_we[victim_q] = 1'b1;
          plru_we           = 1'b1;
          plru_way          = victim_q;
          enable_d          = 1'b0;
          state_d           = REFILL_OK;
        end
      end
      REFILL_OK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // An abandoned request must not leave a partial line behind.
    if (rst_i) begin
      line_we = '0;
      word_we = '0;
      plru_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      victim_q     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      state        <= state_d;
      victim_q     <= victim_d;
      mem_enable_o <= enable_d;
      mem_write_o  <= write_d;
      mem_addr_o   <= addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_data_o <= wb_data_d;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_hits_o   <= '0;
      stat_misses_o <= '0;
    end else begin
      if (req && !p1_stall_o)             stat_hits_o   <= stat_hits_o + 32'd1;
      if (state == IDLE && req && !hit)   stat_misses_o <= stat_misses_o + 32'd1;
    end
  end
`else
  assign stat_hits_o   = '0;
  assign stat_misses_o = '0;
`endif

endmodule

// File: tb/tb_dcache_nway_top.sv
// Directed scoreboard bench for dcache_nway_top (2-way and 4-way instances).
// Counter expectations follow DCACHE_STATS_EN.
module tb_dcache_nway_top;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] mem_data_i;
  logic         ack, ack2, ack4, sel4;
  logic [31:0]  p1_data_i, p1_addr_i;
  logic         rd, wr;

  logic [255:0] mdo2, mdo4, mdo;
  logic [31:0]  mao2, mao4, mao, pdo2, pdo4, pdo, sh2, sh4, sh, sm2, sm4, sm;
  logic         men2, men4, men, mwr2, mwr4, mwr, st2, st4, stall;

  always #5 clk = ~clk;

  assign ack2  = ack & ~sel4;
  assign ack4  = ack & sel4;
  assign mdo   = sel4 ? mdo4 : mdo2;
  assign mao   = sel4 ? mao4 : mao2;
  assign men   = sel4 ? men4 : men2;
  assign mwr   = sel4 ? mwr4 : mwr2;
  assign pdo   = sel4 ? pdo4 : pdo2;
  assign stall = sel4 ? st4  : st2;
  assign sh    = sel4 ? sh4  : sh2;
  assign sm    = sel4 ? sm4  : sm2;

  dcache_nway_top #(.WAYS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .mem_data_i(mem_data_i), .mem_ack_i(ack2),
    .mem_data_o(mdo2), .mem_addr_o(mao2), .mem_enable_o(men2), .mem_write_o(mwr2),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i), .p1_MemRead_i(rd), .p1_MemWrite_i(wr),
    .p1_data_o(pdo2), .p1_stall_o(st2), .stat_hits_o(sh2), .stat_misses_o(sm2)
  );

  dcache_nway_top #(.WAYS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .mem_data_i(mem_data_i), .mem_ack_i(ack4),
    .mem_data_o(mdo4), .mem_addr_o(mao4), .mem_enable_o(men4), .mem_write_o(mwr4),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i), .p1_MemRead_i(rd), .p1_MemWrite_i(wr),
    .p1_data_o(pdo4), .p1_stall_o(st4), .stat_hits_o(sh4), .stat_misses_o(sm4)
  );

  typedef struct packed { logic wr; logic [31:0] addr; } memop_t;

  memop_t       exp_mem_q [$];
  logic [31:0]  exp_data_q [$];
  logic [255:0] mem_model [logic [26:0]];
  logic [31:0]  shadow [logic [29:0]];
  int           total = 0;
  int           bad = 0;

  // Untouched memory holds a pattern derived from each word's own address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a[31:5])) return mem_model[a[31:5]];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word({a[31:5], 3'(k), 2'b00});
    return l;
  endfunction

  function automatic logic [31:0] cpu_word(input logic [31:0] a);
    if (shadow.exists(a[31:2])) return shadow[a[31:2]];
    return init_word(a);
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input logic w, input logic [31:0] a);
    memop_t e;
    e.wr   = w;
    e.addr = a;
    exp_mem_q.push_back(e);
  endtask

  // One CPU access held until the stall drops; memory acks after lat idle enable cycles.
  task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        input int lat, output int stalls);
    int     cnt;
    bit     done;
    memop_t e;
    cnt    = 0;
    done   = 1'b0;
    stalls = 0;
    if (is_wr) shadow[a[31:2]] = d;
    else       exp_data_q.push_back(cpu_word(a));
    @(negedge clk);
    p1_addr_i = a;
    p1_data_i = d;
    rd        = !is_wr;
    wr        = is_wr;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      ack = 1'b0;
      if (!stall) begin
        done = 1'b1;
        if (!is_wr) check("load_data", pdo, exp_data_q.pop_front());
      end else begin
        stalls++;
        if (men) begin
          if (cnt == lat) begin
            ack = 1'b1;
            cnt = 0;
            if (exp_mem_q.size() != 0) e = exp_mem_q.pop_front();
            else e = '1;
            check("mem_op", {mwr, mao}, {e.wr, e.addr});
            if (mwr) mem_model[mao[31:5]] = mdo;
            else     mem_data_i = line_of(mao);
          end else begin
            cnt++;
          end
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) check("access_timeout", stall, 0);
    @(negedge clk);
    rd  = 1'b0;
    wr  = 1'b0;
    ack = 1'b0;
  endtask

  initial begin
    int           s;
    int           c;
    logic [255:0] l;
    logic [31:0]  a;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; ack = 1'b0; sel4 = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; mem_data_i = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_enable", men, 0);
    check("rst_write", mwr, 0);
    check("rst_addr", mao, 0);
    check("rst_hits", sh, 0);
    @(negedge clk);
    rst = 1'b0; rd = 1'b1; p1_addr_i = 32'h0000_0404;
    #1;
    check("rst_stall_eq_req", stall, 1);
    rd = 1'b0;

    // Cold read: clean miss, memory answers after 2 idle cycles.
    exp_mem(1'b0, 32'h0000_0400);
    access(1'b0, 32'h0000_0404, 32'h0, 2, s);
    check("cold_stall_cycles", s, 6);
    check("cold_stat_misses", sm, STATS ? 1 : 0);

    access(1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 0, s);
    check("write_hit_stall", s, 0);
    access(1'b0, 32'h0000_0408, 32'h0, 0, s);
    check("read_after_write_stall", s, 0);

    // Set 0: A=0x400 (way0, dirty), B=0x800 (way1, dirty), touch A, then C=0xC00 evicts B.
    exp_mem(1'b0, 32'h0000_0800);
    access(1'b1, 32'h0000_0800, 32'h1234_5678, 1, s);
    access(1'b0, 32'h0000_0404, 32'h0, 0, s);
    check("touch_a_stall", s, 0);
    exp_mem(1'b1, 32'h0000_0800);
    exp_mem(1'b0, 32'h0000_0C00);
    access(1'b0, 32'h0000_0C04, 32'h0, 1, s);
    l = line_of(32'h0000_0800);
    check("wb_b_word0", l[31:0], 32'h1234_5678);
    check("wb_b_word1", l[63:32], init_word(32'h0000_0804));
    access(1'b0, 32'h0000_0408, 32'h0, 0, s);
    check("a_retained_stall", s, 0);
    // A was touched last, so clean C is the victim and B comes back from memory.
    exp_mem(1'b0, 32'h0000_0800);
    access(1'b0, 32'h0000_0800, 32'h0, 0, s);
    check("b_reload_stall", s, 4);

    // Reset while REFILL waits for its ack; a late ack must be ignored.
    @(negedge clk);
    rd = 1'b1; p1_addr_i = 32'h0000_2424;
    c = 0;
    #1;
    while (!men && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("reached_refill", men, 1);
    rst = 1'b1; ack = 1'b1; mem_data_i = '1; rd = 1'b0;
    @(negedge clk);
    #1;
    check("midop_rst_enable", men, 0);
    check("midop_rst_write", mwr, 0);
    check("midop_rst_addr", mao, 0);
    rst = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    exp_mem(1'b0, 32'h0000_2420);
    access(1'b0, 32'h0000_2424, 32'h0, 0, s);
    check("post_rst_read_misses", s, 4);

    // Three misses in total since reset, then ten hits.
    exp_mem(1'b0, 32'h0000_4000);
    access(1'b0, 32'h0000_4004, 32'h0, 1, s);
    exp_mem(1'b0, 32'h0000_4020);
    access(1'b0, 32'h0000_4028, 32'h0, 0, s);
    for (int i = 0; i < 10; i++) begin
      a = (i % 3 == 0) ? 32'h0000_2424 : (i % 3 == 1) ? 32'h0000_4004 : 32'h0000_4028;
      access(1'b0, a, 32'h0, 0, s);
      check("stats_hit_stall", s, 0);
    end
    check("stat_hits", sh, STATS ? 13 : 0);
    check("stat_misses", sm, STATS ? 3 : 0);

    // 4-way instance: four dirty fills of set 0, then two evictions.
    @(negedge clk);
    rst = 1'b1; sel4 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_mem(1'b0, 32'h0000_0400);
    access(1'b1, 32'h0000_0400, 32'h0000_00A0, 0, s);
    exp_mem(1'b0, 32'h0000_0800);
    access(1'b1, 32'h0000_0800, 32'h0000_00B0, 0, s);
    exp_mem(1'b0, 32'h0000_0C00);
    access(1'b1, 32'h0000_0C00, 32'h0000_00C0, 0, s);
    exp_mem(1'b0, 32'h0000_1000);
    access(1'b1, 32'h0000_1000, 32'h0000_00D0, 0, s);
    // Tree after filling ways 0..3 in order points at way0; after refilling way0 it points at way2.
    exp_mem(1'b1, 32'h0000_0400);
    exp_mem(1'b0, 32'h0000_1400);
    access(1'b1, 32'h0000_1400, 32'h0000_00E0, 1, s);
    l = line_of(32'h0000_0400);
    check("w4_wb_way0_word0", l[31:0], 32'h0000_00A0);
    exp_mem(1'b1, 32'h0000_0C00);
    exp_mem(1'b0, 32'h0000_1800);
    access(1'b1, 32'h0000_1800, 32'h0000_00F0, 0, s);
    l = line_of(32'h0000_0C00);
    check("w4_wb_way2_word0", l[31:0], 32'h0000_00C0);
    access(1'b0, 32'h0000_1400, 32'h0, 0, s);
    check("w4_hit_way0_stall", s, 0);
    access(1'b0, 32'h0000_1004, 32'h0, 0, s);
    check("w4_hit_way3_stall", s, 0);

    check("mem_queue_drained", exp_mem_q.size(), 0);
    check("data_queue_drained", exp_data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
